// File: rtl/fib_req_arbiter.sv
// fib_req_arbiter: round-robin sharing of one Fibonacci engine among NUM_REQ requesters
module fib_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int N_WIDTH   = 8,
  parameter int RES_WIDTH = 8,
  parameter int TIMEOUT   = 5000,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*N_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic [RES_WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]            res_id,
  output logic                       busy,
  output logic                       eng_stb,
  output logic [N_WIDTH-1:0]         eng_n,
  input  logic                       eng_busy,
  input  logic [RES_WIDTH-1:0]       eng_result
);
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, gnt, pick;
  logic [15:0] wdog;
  logic expired;
  assign expired = wdog == 16'(TIMEOUT - 1);
  // scan from the highest offset down so the lowest offset from ptr wins
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) pick = ID_W'((int'(ptr) + k) % NUM_REQ);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |req ? ISSUE : IDLE;
      ISSUE:   state_nx = SETTLE;
      SETTLE:  state_nx = WAIT;
      WAIT:    state_nx = (!eng_busy || expired) ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      eng_n    <= '0;
      wdog     <= '0;
      err      <= 1'b0;
      res_data <= '0;
      res_id   <= '0;
      done     <= '0;
      busy     <= 1'b0;
      eng_stb  <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= state_nx != IDLE;
      eng_stb <= state_nx == ISSUE;
      done    <= (state_nx == DONE) ? NUM_REQ'(1) << gnt : '0;
      if (state == IDLE && |req) begin
        gnt   <= pick;
        eng_n <= req_n[int'(pick)*N_WIDTH +: N_WIDTH];
      end
      if (state == ISSUE) begin
        ptr  <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        wdog <= '0;
      end
      if (state == WAIT) begin
        if (!eng_busy) begin
          res_data <= eng_result;
          err      <= 1'b0;
          res_id   <= gnt;
        end else if (expired) begin
          res_data <= '0;
          err      <= 1'b1;
          res_id   <= gnt;
        end else begin
          wdog <= wdog + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fib_req_arbiter.sv
// tb_fib_req_arbiter: table-driven scoreboard bench with a behavioural Fibonacci engine
module tb_fib_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, done;
  logic [31:0] req_n = '0;
  logic err, busy, eng_stb, eng_busy;
  logic [7:0] res_data, eng_n, eng_result;
  logic [1:0] res_id;
  int total = 0, bad = 0, cyc = 0, stb_cnt = 0, bcfg = 0, cnt = 0;
  bit stuck = 1'b0, got_done;
  logic [7:0] eres = '0;

  fib_req_arbiter #(.NUM_REQ(4), .N_WIDTH(8), .RES_WIDTH(8), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n), .done(done), .err(err),
    .res_data(res_data), .res_id(res_id), .busy(busy), .eng_stb(eng_stb),
    .eng_n(eng_n), .eng_busy(eng_busy), .eng_result(eng_result));

  always #5 clk = ~clk;

  function automatic logic [7:0] fib(input logic [7:0] n);
    logic [7:0] a = 8'd0, b = 8'd1, t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // engine: busy from the cycle after the strobe for bcfg+1 cycles, or forever when stuck
  always @(posedge clk) begin
    if (eng_stb) begin
      cnt  <= bcfg + 1;
      eres <= fib(eng_n);
    end else if (cnt != 0) cnt <= cnt - 1;
  end
  assign eng_busy = stuck || cnt != 0;
  assign eng_result = eres;

  typedef struct {
    logic [3:0] rq;
    logic [31:0] n;
    int b;
    bit stk;
    int id;
    logic [7:0] data;
    bit er;
  } vec_t;
  typedef struct {
    int id;
    logic [7:0] data;
    bit er;
    logic [7:0] n;
    int t0;
    int lat;
  } exp_t;
  vec_t vt[12];
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (eng_stb) begin
      stb_cnt++;
      if (q.size() == 0) chk("stb_without_request", q.size(), 1);
      else chk("eng_n_at_stb", eng_n, q[0].n);
    end
    if (|done) begin
      if (q.size() == 0) chk("done_unexpected", done, 0);
      else begin
        e = q.pop_front();
        chk("done_onehot", done, 32'(1) << e.id);
        chk("res_id", res_id, e.id);
        chk("res_data", res_data, e.data);
        chk("err", err, e.er);
        chk("latency", cyc - e.t0, e.lat);
        chk("stb_count", stb_cnt, 1);
      end
      stb_cnt = 0;
      got_done = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic push(input int id, input logic [7:0] data, input bit er, input logic [7:0] n, input int lat);
    q.push_back('{id: id, data: data, er: er, n: n, t0: cyc, lat: lat});
  endtask

  task automatic wait_done();
    got_done = 1'b0;
    for (int i = 0; i < 100 && !got_done; i++) step();
    if (!got_done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_stb", eng_stb, 0);
    chk("rst_eng_n", eng_n, 0);
  endtask

  initial begin
    vt[0]  = '{4'b1111, {8'd13, 8'd7, 8'd1, 8'd0}, 0, 1'b0, 0, 8'd0, 1'b0};
    vt[1]  = '{4'b1111, {8'd13, 8'd7, 8'd1, 8'd0}, 3, 1'b0, 1, 8'd1, 1'b0};
    vt[2]  = '{4'b1111, {8'd13, 8'd7, 8'd1, 8'd0}, 1, 1'b0, 2, 8'd13, 1'b0};
    vt[3]  = '{4'b1111, {8'd13, 8'd7, 8'd1, 8'd0}, 7, 1'b0, 3, 8'd233, 1'b0};
    vt[4]  = '{4'b1111, {8'd13, 8'd7, 8'd1, 8'd0}, 2, 1'b0, 0, 8'd0, 1'b0};
    vt[5]  = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd10}, 12, 1'b0, 0, 8'd55, 1'b0};
    vt[6]  = '{4'b1010, {8'd12, 8'd0, 8'd5, 8'd0}, 0, 1'b0, 1, 8'd5, 1'b0};
    vt[7]  = '{4'b1010, {8'd12, 8'd0, 8'd5, 8'd0}, 4, 1'b0, 3, 8'd144, 1'b0};
    vt[8]  = '{4'b1010, {8'd12, 8'd0, 8'd5, 8'd0}, 1, 1'b0, 1, 8'd5, 1'b0};
    vt[9]  = '{4'b1010, {8'd12, 8'd0, 8'd5, 8'd0}, 2, 1'b0, 3, 8'd144, 1'b0};
    vt[10] = '{4'b0100, {8'd0, 8'd4, 8'd0, 8'd0}, 0, 1'b1, 2, 8'd0, 1'b1};
    vt[11] = '{4'b0100, {8'd0, 8'd6, 8'd0, 8'd0}, 2, 1'b0, 2, 8'd8, 1'b0};
    step();
    step();
    check_reset_outputs();
    rst = 1'b0;
    foreach (vt[i]) begin
      req   = vt[i].rq;
      req_n = vt[i].n;
      bcfg  = vt[i].b;
      stuck = vt[i].stk;
      push(vt[i].id, vt[i].data, vt[i].er, vt[i].n[vt[i].id*8 +: 8], vt[i].stk ? 23 : 4 + vt[i].b);
      wait_done();
      step();
    end
    // request withdrawn and n rewritten while the engine is working
    req   = 4'b0001;
    req_n = {8'd0, 8'd0, 8'd0, 8'd20};
    bcfg  = 5;
    stuck = 1'b0;
    push(0, 8'd109, 1'b0, 8'd20, 9);
    step();
    step();
    step();
    req   = 4'b0000;
    req_n = {8'd0, 8'd0, 8'd0, 8'd3};
    wait_done();
    chk("eng_n_held", eng_n, 20);
    for (int i = 0; i < 4; i++) step();
    chk("idle_after_drop", busy, 0);
    // reset while waiting on the engine
    req   = 4'b1000;
    req_n = {8'd9, 8'd0, 8'd0, 8'd0};
    bcfg  = 20;
    push(3, 8'd34, 1'b0, 8'd9, 0);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    check_reset_outputs();
    q.delete();
    stb_cnt = 0;
    rst  = 1'b0;
    bcfg = 1;
    push(3, 8'd34, 1'b0, 8'd9, 5);
    wait_done();
    step();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fib_req_arbiter.md
# fib_req_arbiter

Round-robin controller that shares one Fibonacci engine (strobe/busy handshake, 8-bit n in, 8-bit result out) among NUM_REQ requesters. It sits between the requester ports and the engine: it selects one request, issues the strobe, waits out the engine's busy period under a watchdog, and returns the result with a one-cycle done pulse to the winning requester.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- N_WIDTH, 8: width of each requested index n.
- RES_WIDTH, 8: width of engine result.
- TIMEOUT, 5000: max cycles in WAIT with eng_busy high before abort; must be < 2^16.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held until its done pulse.
- req_n  in  NUM_REQ*N_WIDTH  packed n per requester; slice i = bits [i*N_WIDTH +: N_WIDTH].
- done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- err  out  1  valid with done; 1 = watchdog abort.
- res_data  out  RES_WIDTH  result, valid with done, held until next done.
- res_id  out  clog2(NUM_REQ)  index of the completed requester, held with res_data.
- busy  out  1  high in every state except IDLE.
- eng_stb  out  1  engine start strobe, exactly one cycle per grant.
- eng_n  out  N_WIDTH  latched n; stable from ISSUE until next grant.
- eng_busy  in  1  engine busy.
- eng_result  in  RES_WIDTH  engine output, valid when eng_busy low after strobe.

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT, DONE.
- IDLE: if req != 0, pick first set bit scanning ptr, ptr+1, ... mod NUM_REQ; latch index to gnt and req_n slice to eng_n; go ISSUE. Otherwise stay.
- ISSUE: eng_stb=1; ptr <= (gnt+1) mod NUM_REQ; clear watchdog; go SETTLE.
- SETTLE: eng_stb=0; one cycle for engine to raise busy; go WAIT.
- WAIT: if eng_busy=0, capture eng_result into res_data, err<=0, go DONE. Else if watchdog == TIMEOUT-1, res_data<=0, err<=1, go DONE. Else watchdog+1.
- DONE: done[gnt]=1, res_id=gnt; go IDLE.
- Request changes: req/req_n sampled only in IDLE; deassertion or n change after grant has no effect, operation completes and done still pulses.
- A requester still asserting req in the IDLE after its done is re-arbitrated as a new request at lowest priority (ptr already past it).
- Watchdog: 16-bit, counts WAIT cycles only; no wrap possible since TIMEOUT < 2^16.
- No arithmetic on the result; eng_result passed through unmodified.

## Timing
- Reset (any state, including mid-operation): state=IDLE, ptr=0, eng_stb=0, eng_n=0, done=0, err=0, res_data=0, res_id=0, busy=0, watchdog=0. An engine left busy is ignored; next grant proceeds normally.
- req seen at edge of cycle 0 (IDLE) -> eng_stb high cycle 1 -> SETTLE cycle 2 -> first eng_busy sample cycle 3.
- Engine never busy: done at cycle 4; minimum 5 cycles per request including the return to IDLE.
- Engine busy for B cycles in WAIT: done at cycle 4+B.
- Timeout: busy held forever -> done with err=1 at cycle 3+TIMEOUT.
- Back-to-back: next eng_stb no earlier than 2 cycles after a done pulse.
- Outputs are all registered; no combinational path from req or eng_busy to any output.

## Test plan
- Single requester: reset, req[0]=1, n=10, engine model busy 12 cycles -> one eng_stb with eng_n=10, done[0] at cycle 16, res_data=55, res_id=0, err=0.
- Round robin: all 4 req high with n=0,1,7,13 held, ptr=0 -> grant order 0,1,2,3,0...; results 0,1,13,233; each done one-hot.
- Fairness after grant: req[1] and req[3] held, n=5 and 12 -> order 1,3,1,3; results 5 and 144 alternate; no requester starved.
- Watchdog: TIMEOUT=20, engine busy stuck high, req[2]=1 -> done[2] at cycle 23, err=1, res_data=0; next request with normal engine returns err=0.
- Mid-operation changes: req[0] dropped and req_n changed during WAIT -> done[0] still pulses with result for originally latched n; eng_n unchanged.
- Reset mid-operation: assert rst during WAIT -> next cycle all outputs at reset values, no done pulse; after release, req[3]=1 n=9 -> res_data=34, res_id=3.
